// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the gcd unit and its requester.
//   GCD_W            operand/result width used by both blocks
//   REQ_*_IDX        bit positions of the requester's one-hot state vector
//   req_state_e      one-hot state type of the requester FSM
// ---------------------------------------------------------------------------
package gcd_pkg;

  localparam int GCD_W = 8;

  localparam int REQ_IDLE_IDX  = 0;
  localparam int REQ_ISSUE_IDX = 1;
  localparam int REQ_WAIT_IDX  = 2;
  localparam int REQ_RESP_IDX  = 3;
  localparam int REQ_NSTATES   = 4;

  // Each encoding sets exactly the bit named by the matching *_IDX constant.
  typedef enum logic [REQ_NSTATES-1:0] {
    REQ_IDLE  = 4'b0001,
    REQ_ISSUE = 4'b0010,
    REQ_WAIT  = 4'b0100,
    REQ_RESP  = 4'b1000
  } req_state_e;

endpackage

// File: rtl/gcd_req_timer.sv
// ---------------------------------------------------------------------------
// gcd_req_timer
// Wait-cycle counter for the gcd requester's timeout abort. Only instantiated
// when GCD_REQ_TIMEOUT_EN is defined.
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   clr_i     clear the count (issue cycle)
//   en_i      count this cycle (waiting, done not yet seen)
//   expire_o  high on the counting cycle that brings the count to TIMEOUT
// ---------------------------------------------------------------------------
module gcd_req_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count sits at k during the (k+1)-th waiting cycle, so flagging at
  // TIMEOUT-1 makes the wait last exactly TIMEOUT cycles.
  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_requester.sv
// ---------------------------------------------------------------------------
// gcd_requester
// Initiator-side sequencer for one gcd unit: accepts an operand pair on a
// valid/ready request channel, pulses the unit's start for one cycle, waits
// for its sticky done flag and returns the result on a valid/ready response
// channel together with the job tag.
//
// Optional feature macro: GCD_REQ_TIMEOUT_EN
//   defined   -> abort a job after TIMEOUT wait cycles (rsp_err = 1, ret = 0)
//   undefined -> wait for done indefinitely, rsp_err tied to 0
//
// Ports:
//   clk, rst_n                    clock / asynchronous active-low reset
//   req_valid, req_ready          request handshake
//   req_a, req_b, req_tag         operands and job tag
//   rsp_valid, rsp_ready          response handshake
//   rsp_ret, rsp_tag, rsp_err     result, echoed tag, timeout flag
//   gcd_start, gcd_a, gcd_b       to the gcd unit (start, a_in, b_in)
//   gcd_done, gcd_ret             from the gcd unit (done_out, ret_out)
//   busy                          high whenever not idle
// ---------------------------------------------------------------------------
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_ret,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             gcd_start,
  output logic [W-1:0]     gcd_a,
  output logic [W-1:0]     gcd_b,
  input  logic             gcd_done,
  input  logic [W-1:0]     gcd_ret,
  output logic             busy
);

  if (TIMEOUT < 8 || TIMEOUT > 255) begin : g_bad_timeout
    $error("gcd_requester: TIMEOUT must lie in 8..255");
  end

  req_state_e state_q;
  req_state_e state_d;

  logic             in_idle;
  logic             in_issue;
  logic             in_wait;
  logic             in_resp;
  logic             accept;
  logic             timeout_expire;

  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [W-1:0]     ret_q, ret_d;

  assign in_idle  = state_q[REQ_IDLE_IDX];
  assign in_issue = state_q[REQ_ISSUE_IDX];
  assign in_wait  = state_q[REQ_WAIT_IDX];
  assign in_resp  = state_q[REQ_RESP_IDX];
  assign accept   = in_idle && req_valid;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // gcd_done is only looked at in WAIT: the unit's flag is sticky from the
  // previous job and only drops the cycle after start, which is the first
  // WAIT cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (in_idle) begin
      if (req_valid) state_d = REQ_ISSUE;
    end else if (in_issue) begin
      state_d = REQ_WAIT;
    end else if (in_wait) begin
      if (gcd_done || timeout_expire) state_d = REQ_RESP;
    end else if (in_resp) begin
      if (rsp_ready) state_d = REQ_IDLE;
    end else begin
      state_d = REQ_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready = in_idle;
    gcd_start = in_issue;
    rsp_valid = in_resp;
    busy      = !in_idle;
  end

  // -------------------------------------------------------------------------
  // Job and result registers
  // -------------------------------------------------------------------------
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    tag_d  = tag_q;
    ret_d  = ret_q;
    if (accept) begin
      op_a_d = req_a;
      op_b_d = req_b;
      tag_d  = req_tag;
    end
    // Done has priority over a simultaneous timeout expiry.
    if (in_wait) begin
      if (gcd_done) begin
        ret_d = gcd_ret;
      end else if (timeout_expire) begin
        ret_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
      tag_q  <= '0;
      ret_q  <= '0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      tag_q  <= tag_d;
      ret_q  <= ret_d;
    end
  end

  // The captured operands feed the unit directly; they only change on an
  // accept, so they are stable through ISSUE and WAIT.
  assign gcd_a   = op_a_q;
  assign gcd_b   = op_b_q;
  assign rsp_ret = ret_q;
  assign rsp_tag = tag_q;

  // -------------------------------------------------------------------------
  // Optional timeout
  // -------------------------------------------------------------------------
`ifdef GCD_REQ_TIMEOUT_EN
  logic err_q, err_d;

  gcd_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (in_issue),
    .en_i     (in_wait && !gcd_done),
    .expire_o (timeout_expire)
  );

  always_comb begin
    err_d = err_q;
    if (in_wait) begin
      if (gcd_done) begin
        err_d = 1'b0;
      end else if (timeout_expire) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout_expire = 1'b0;
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_requester.sv
// ---------------------------------------------------------------------------
// tb_gcd_requester
// Self-checking bench for gcd_requester. A behavioural gcd unit (sticky done,
// no reset, done 4 + 2*steps cycles after it samples start) drives the DUT;
// expected results come from a plain Euclid function and a tag/result queue.
// With GCD_REQ_TIMEOUT_EN defined a second instance (TIMEOUT = 8) with a
// bench-controlled done line exercises the abort path.
// ---------------------------------------------------------------------------
module tb_gcd_requester;
  import gcd_pkg::*;

  localparam int W     = GCD_W;
  localparam int TAG_W = 4;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [W-1:0]     req_a = '0;
  logic [W-1:0]     req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_ret;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             gcd_start;
  logic [W-1:0]     gcd_a;
  logic [W-1:0]     gcd_b;
  logic             gcd_done;
  logic [W-1:0]     gcd_ret;
  logic             busy;

  always #5 clk = ~clk;

  gcd_requester #(.W(W), .TAG_W(TAG_W), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ret(rsp_ret), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_ret(gcd_ret), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference arithmetic
  function automatic int sw_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int gcd_steps(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    int s = 0;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
      s++;
    end
    return s;
  endfunction

  // Behavioural gcd unit
  logic         mdl_done = 1'b0;
  logic [W-1:0] mdl_ret  = '0;
  logic [W-1:0] mdl_res  = '0;
  int           mdl_cnt  = 0;
  bit           mdl_busy = 1'b0;

  always @(posedge clk) begin
    if (gcd_start) begin
      mdl_done <= 1'b0;
      mdl_busy <= 1'b1;
      mdl_cnt  <= 3 + 2 * gcd_steps(int'(gcd_a), int'(gcd_b));
      mdl_res  <= W'(sw_gcd(int'(gcd_a), int'(gcd_b)));
    end else if (mdl_busy) begin
      if (mdl_cnt == 0) begin
        mdl_done <= 1'b1;
        mdl_ret  <= mdl_res;
        mdl_busy <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  assign gcd_done = mdl_done;
  assign gcd_ret  = mdl_ret;

`ifdef GCD_REQ_TIMEOUT_EN
  logic             t_req_valid = 1'b0;
  logic             t_req_ready;
  logic             t_rsp_valid;
  logic             t_rsp_ready = 1'b0;
  logic [W-1:0]     t_rsp_ret;
  logic [TAG_W-1:0] t_rsp_tag;
  logic             t_rsp_err;
  logic             t_start;
  logic [W-1:0]     t_gcd_a;
  logic [W-1:0]     t_gcd_b;
  logic             t_done = 1'b0;
  logic [W-1:0]     t_ret = '0;
  logic             t_busy;

  gcd_requester #(.W(W), .TAG_W(TAG_W), .TIMEOUT(TMO)) dut_tmo (
    .clk(clk), .rst_n(rst_n),
    .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_a(W'(48)), .req_b(W'(18)), .req_tag(TAG_W'(2)),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
    .rsp_ret(t_rsp_ret), .rsp_tag(t_rsp_tag), .rsp_err(t_rsp_err),
    .gcd_start(t_start), .gcd_a(t_gcd_a), .gcd_b(t_gcd_b),
    .gcd_done(t_done), .gcd_ret(t_ret), .busy(t_busy)
  );

  task automatic run_tmo(input bit inject);
    int n = 0;
    @(negedge clk);
    t_req_valid = 1'b1;
    t_rsp_ready = 1'b1;
    chk("tmo_req_ready", t_req_ready, 1);
    @(negedge clk);
    t_req_valid = 1'b0;
    chk("tmo_start", t_start, 1);
    while (!t_rsp_valid && n < 100) begin
      t_done = inject && (n == TMO);
      t_ret  = 8'h5A;
      @(negedge clk);
      n++;
    end
    t_done = 1'b0;
    chk("tmo_lat", n, TMO + 1);
    chk("tmo_err", t_rsp_err, inject ? 0 : 1);
    chk("tmo_ret", t_rsp_ret, inject ? 32'h5A : 0);
    chk("tmo_tag", t_rsp_tag, 2);
    chk("tmo_gcd_a", t_gcd_a, 48);
    chk("tmo_gcd_b", t_gcd_b, 18);
    $display("tmo job: inject=%0d lat=%0d ret=%0d err=%0d", inject, n, t_rsp_ret, t_rsp_err);
    @(negedge clk);
    t_rsp_ready = 1'b0;
    chk("tmo_idle", t_busy, 0);
  endtask
`endif

  task automatic check_reset(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 1);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_ret"},   rsp_ret,   0);
    chk({pfx, "_rsp_tag"},   rsp_tag,   0);
    chk({pfx, "_rsp_err"},   rsp_err,   0);
    chk({pfx, "_gcd_start"}, gcd_start, 0);
    chk({pfx, "_gcd_a"},     gcd_a,     0);
    chk({pfx, "_gcd_b"},     gcd_b,     0);
    chk({pfx, "_busy"},      busy,      0);
  endtask

  // One directed job. exp_lat counts rising edges from the accept edge to the
  // first cycle rsp_valid is seen; hold keeps rsp_ready low that many cycles.
  task automatic run_job(input int a, input int b, input int tg,
                         input int exp_ret, input int exp_lat, input int hold);
    int n = 0;
    int starts = 0;
    @(negedge clk);
    req_a     = W'(a);
    req_b     = W'(b);
    req_tag   = TAG_W'(tg);
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy", busy, 1);
    n = 0;
    while (!rsp_valid && n < 400) begin
      if (gcd_start) starts++;
      @(negedge clk);
      n++;
    end
    chk("rsp_lat", n, exp_lat);
    chk("start_cnt", starts, 1);
    chk("rsp_ret", rsp_ret, exp_ret);
    chk("rsp_tag", rsp_tag, tg);
    chk("rsp_err", rsp_err, 0);
    $display("job: a=%0d b=%0d tag=%0d ret=%0d lat=%0d", a, b, tg, rsp_ret, n);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_ret", rsp_ret, exp_ret);
      chk("hold_tag", rsp_tag, tg);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  typedef struct {
    int a;
    int b;
    int tag;
    int ret;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    // Reset state
    @(negedge clk);
    check_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed jobs
    run_job(48, 18, 3, 6, 12, 0);
    run_job(7, 0, 5, 7, 6, 0);
    run_job(0, 0, 9, 0, 6, 0);
    run_job(100, 75, 10, 25, 10, 10);
    run_job(9, 6, 6, 3, 10, 0);

    // Reset in the middle of a job
    begin
      int n = 0;
      @(negedge clk);
      req_a = 8'd255; req_b = 8'd1; req_tag = 4'hF; req_valid = 1'b1;
      while (!req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_gcd_a", gcd_a, 255);
      #2 rst_n = 1'b0;
      #1 check_reset("mid");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
    end
    run_job(12, 8, 1, 4, 10, 0);

`ifdef GCD_REQ_TIMEOUT_EN
    run_tmo(1'b0);
    run_tmo(1'b1);
`endif

    // Streaming with random gaps on both channels
    fork
      begin : drv
        for (int i = 0; i < 50; i++) begin
          int da;
          int db;
          int dt;
          int wn;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          da = (i % 10 == 3) ? 0 : int'($urandom_range(0, 255));
          db = (i % 7 == 2)  ? 0 : int'($urandom_range(0, 255));
          dt = int'($urandom_range(0, 15));
          req_a = W'(da); req_b = W'(db); req_tag = TAG_W'(dt);
          req_valid = 1'b1;
          wn = 0;
          while (!req_ready && wn < 500) begin
            @(negedge clk);
            wn++;
          end
          chk("stream_accept", req_ready, 1);
          exp_q.push_back('{a: da, b: db, tag: dt, ret: sw_gcd(da, db)});
          @(negedge clk);
          req_valid = 1'b0;
        end
      end
      begin : mon
        int got = 0;
        int cyc = 0;
        exp_t e;
        while (got < 50 && cyc < 20000) begin
          rsp_ready = 1'($urandom_range(0, 1));
          if (rsp_valid && rsp_ready) begin
            chk("stream_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("stream_ret", rsp_ret, e.ret);
              chk("stream_tag", rsp_tag, e.tag);
              chk("stream_err", rsp_err, 0);
              $display("stream job %0d: a=%0d b=%0d tag=%0d ret=%0d", got, e.a, e.b, rsp_tag, rsp_ret);
            end
            got++;
          end
          @(negedge clk);
          cyc++;
        end
        rsp_ready = 1'b0;
        chk("stream_count", got, 50);
      end
    join

    repeat (2) @(negedge clk);
    chk("final_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
